// File: rtl/sr_pq_r.sv
`default_nettype none
// ============================================================================
//  Module      : sr_pq_r
//  Description : Shift-register priority queue with per-stage valid bits.
//                Single-cycle enqueue, dequeue and replace; min- or
//                max-ordered head; FIFO order among equal keys.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_pq_r #(
   parameter int CAPACITY = 16,
   parameter int KEY_W    = 16,
   parameter int VAL_W    = 16,
   parameter int MAX_MODE = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enq,
   input  logic                            deq,
   input  logic [KEY_W-1:0]                ki,
   input  logic [VAL_W-1:0]                vi,
   output logic [KEY_W-1:0]                ko,
   output logic [VAL_W-1:0]                vo,
   output logic                            empty,
   output logic                            full,
   output logic [$clog2(CAPACITY+1)-1:0]   count,
   output logic                            ovf,
   output logic                            udf,
   output logic                            busy
);

   localparam int               CNT_W     = $clog2(CAPACITY+1);
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   // Stage storage; index 0 is the head.
   logic [CAPACITY-1:0] valid_q, valid_d;
   logic [KEY_W-1:0]    key_q [CAPACITY];
   logic [KEY_W-1:0]    key_d [CAPACITY];
   logic [VAL_W-1:0]    val_q [CAPACITY];
   logic [VAL_W-1:0]    val_d [CAPACITY];
   logic [CNT_W-1:0]    count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                udf_q, udf_d;

   // Comparator results and their neighbour-shifted views.
   logic [CAPACITY-1:0] pass_w;
   logic [CAPACITY-1:0] prev_pass_w;   // bit i = pass of stage i-1 (1 for head)
   logic [CAPACITY-1:0] next_pass_w;   // bit i = pass of stage i+1 (0 for tail)
   logic [CAPACITY-1:0] here_pass_w;   // pass with the head forced to 1

   // Neighbour contents, so every stage sees predecessor and successor.
   logic [CAPACITY-1:0] valid_prev_w, valid_next_w;
   logic [KEY_W-1:0]    key_prev_w [CAPACITY];
   logic [KEY_W-1:0]    key_next_w [CAPACITY];
   logic [VAL_W-1:0]    val_prev_w [CAPACITY];
   logic [VAL_W-1:0]    val_next_w [CAPACITY];

   logic op_enq_w, op_deq_w, op_rep_w;

   // Effective operation; enq+deq on an empty queue degrades to a plain enqueue.
   assign op_enq_w = enq && (deq ? !valid_q[0] : !valid_q[CAPACITY-1]);
   assign op_deq_w = deq && !enq && valid_q[0];
   assign op_rep_w = enq && deq && valid_q[0];

   // Per-stage comparator: a passing stage sorts ahead of the incoming entry.
   always_comb begin
      pass_w = '0;
      for (int j = 0; j < CAPACITY; j++) begin
         pass_w[j] = valid_q[j] &&
                     ((MAX_MODE != 0) ? (key_q[j] >= ki) : (key_q[j] <= ki));
      end
   end

   assign prev_pass_w = {pass_w[CAPACITY-2:0], 1'b1};
   assign next_pass_w = {1'b0, pass_w[CAPACITY-1:1]};
   assign here_pass_w = pass_w | {{(CAPACITY-1){1'b0}}, 1'b1};

   assign valid_prev_w = {valid_q[CAPACITY-2:0], 1'b0};
   assign valid_next_w = {1'b0, valid_q[CAPACITY-1:1]};

   // Gather each stage's neighbours; the ends see an empty, zeroed stage.
   always_comb begin
      key_prev_w[0]          = '0;
      val_prev_w[0]          = '0;
      key_next_w[CAPACITY-1] = '0;
      val_next_w[CAPACITY-1] = '0;
      for (int i = 1; i < CAPACITY; i++) begin
         key_prev_w[i]   = key_q[i-1];
         val_prev_w[i]   = val_q[i-1];
         key_next_w[i-1] = key_q[i];
         val_next_w[i-1] = val_q[i];
      end
   end

   // Next-state for every stage, occupancy count and error pulses.
   always_comb begin
      valid_d = valid_q;
      key_d   = key_q;
      val_d   = val_q;
      count_d = count_q;
      ovf_d   = enq && !deq && valid_q[CAPACITY-1];
      udf_d   = deq && !enq && !valid_q[0];

      for (int i = 0; i < CAPACITY; i++) begin
         if (op_enq_w) begin
            // Passing stages hold; the first failing stage takes the new
            // entry and everything behind it moves one step toward the tail.
            if (!pass_w[i]) begin
               if (prev_pass_w[i]) begin
                  valid_d[i] = 1'b1;
                  key_d[i]   = ki;
                  val_d[i]   = vi;
               end else begin
                  valid_d[i] = valid_prev_w[i];
                  key_d[i]   = key_prev_w[i];
                  val_d[i]   = val_prev_w[i];
               end
            end
         end else if (op_deq_w) begin
            valid_d[i] = valid_next_w[i];
            key_d[i]   = key_next_w[i];
            val_d[i]   = val_next_w[i];
         end else if (op_rep_w) begin
            // Stages ahead of the insertion point pull forward over the
            // departing head; the insertion point is the last such stage + 1.
            if (next_pass_w[i]) begin
               valid_d[i] = valid_next_w[i];
               key_d[i]   = key_next_w[i];
               val_d[i]   = val_next_w[i];
            end else if (here_pass_w[i]) begin
               valid_d[i] = 1'b1;
               key_d[i]   = ki;
               val_d[i]   = vi;
            end
         end
      end

      if (op_enq_w) begin
         count_d = count_q + C_CNT_ONE;
      end else if (op_deq_w) begin
         count_d = count_q - C_CNT_ONE;
      end
   end

   // State registers; reset discards all contents.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
         for (int i = 0; i < CAPACITY; i++) begin
            key_q[i] <= '0;
            val_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
         for (int i = 0; i < CAPACITY; i++) begin
            key_q[i] <= key_d[i];
            val_q[i] <= val_d[i];
         end
      end
   end

   assign ko    = key_q[0];
   assign vo    = val_q[0];
   assign empty = !valid_q[0];
   assign full  = valid_q[CAPACITY-1];
   assign count = count_q;
   assign ovf   = ovf_q;
   assign udf   = udf_q;
   assign busy  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sr_pq_r.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_pq_r
//  Description : Self-checking bench for sr_pq_r. A min-ordered and a
//                max-ordered instance share stimulus and are compared
//                against an ordered-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_pq_r;

   localparam int CAP = 4;

   logic       clk;
   logic       rst_n;
   logic       enq, deq;
   logic [7:0] ki, vi;

   // Index 0: MAX_MODE=0 instance, index 1: MAX_MODE=1 instance.
   logic [7:0] ko  [2];
   logic [7:0] vo  [2];
   logic [2:0] cnt [2];
   logic       emp [2];
   logic       ful [2];
   logic       ov  [2];
   logic       ud  [2];
   logic       bs  [2];

   int n_vec;
   int n_err;

   // Reference model: entries {key,value} in dequeue order.
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   bit   [1:0]  e_ovf;
   bit   [1:0]  e_udf;

   sr_pq_r #(.CAPACITY(CAP), .KEY_W(8), .VAL_W(8), .MAX_MODE(0)) u_min (
      .clk(clk), .rst(rst_n), .enq(enq), .deq(deq), .ki(ki), .vi(vi),
      .ko(ko[0]), .vo(vo[0]), .empty(emp[0]), .full(ful[0]), .count(cnt[0]),
      .ovf(ov[0]), .udf(ud[0]), .busy(bs[0])
   );

   sr_pq_r #(.CAPACITY(CAP), .KEY_W(8), .VAL_W(8), .MAX_MODE(1)) u_max (
      .clk(clk), .rst(rst_n), .enq(enq), .deq(deq), .ki(ki), .vi(vi),
      .ko(ko[1]), .vo(vo[1]), .empty(emp[1]), .full(ful[1]), .count(cnt[1]),
      .ovf(ov[1]), .udf(ud[1]), .busy(bs[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ordered-list model: a new entry goes behind every entry that sorts at or
   // ahead of it; replace = remove head, then insert.
   task automatic mod_op(input logic [15:0] qi[$], input int mm, input bit e, input bit d,
                         input logic [7:0] k, input logic [7:0] v,
                         output logic [15:0] qo[$], output bit ovo, output bit ufo);
      bit do_ins;
      int pos;
      qo = qi; ovo = 0; ufo = 0; do_ins = 0;
      if (e && d && qi.size() > 0) begin
         void'(qo.pop_front());
         do_ins = 1;
      end else if (e) begin
         if (qi.size() == CAP) ovo = 1;
         else do_ins = 1;
      end else if (d) begin
         if (qi.size() == 0) ufo = 1;
         else void'(qo.pop_front());
      end
      if (do_ins) begin
         pos = 0;
         foreach (qo[n]) begin
            if (mm != 0 ? (qo[n][15:8] >= k) : (qo[n][15:8] <= k)) pos++;
         end
         qo.insert(pos, {k, v});
      end
   endtask

   // One clock: drive inputs, advance model at the edge, settle 1 ns after.
   task automatic cycle(input bit e, input bit d, input logic [7:0] k, input logic [7:0] v);
      logic [15:0] qn[$];
      bit o, u;
      enq = e; deq = d; ki = k; vi = v;
      @(posedge clk);
      mod_op(q0, 0, e, d, k, v, qn, o, u); q0 = qn; e_ovf[0] = o; e_udf[0] = u;
      mod_op(q1, 1, e, d, k, v, qn, o, u); q1 = qn; e_ovf[1] = o; e_udf[1] = u;
      #1;
      enq = 0; deq = 0;
   endtask

   task automatic test_reset();
      for (int m = 0; m < 2; m++) begin
         n_vec++;
         if ({ko[m], vo[m], cnt[m], emp[m], ful[m], ov[m], ud[m], bs[m]} !== {8'd0, 8'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state_m%0d: got ko=%0d vo=%0d cnt=%0d emp=%b ful=%b ovf=%b udf=%b busy=%b want 0 0 0 1 0 0 0 0",
                     m, ko[m], vo[m], cnt[m], emp[m], ful[m], ov[m], ud[m], bs[m]);
         end
      end
   endtask

   task automatic test_enq_order();
      cycle(1, 0, 30, 1);
      cycle(1, 0, 10, 2);
      cycle(1, 0, 20, 3);
      cycle(1, 0, 10, 4);
      n_vec++;
      if ({ko[0], vo[0]} !== {8'd10, 8'd2}) begin
         n_err++; $display("FAIL enq_head: got %0d/%0d want 10/2", ko[0], vo[0]);
      end
      n_vec++;
      if ({cnt[0], ful[0], emp[0]} !== {3'd4, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL enq_full: got cnt=%0d full=%b empty=%b want 4 1 0", cnt[0], ful[0], emp[0]);
      end
      n_vec++;
      if ({ko[1], vo[1]} !== {8'd30, 8'd1}) begin
         n_err++; $display("FAIL enq_head_max: got %0d/%0d want 30/1", ko[1], vo[1]);
      end
   endtask

   task automatic test_overflow_replace();
      cycle(1, 0, 5, 5);
      n_vec++;
      if ({ov[0], ov[1], cnt[0], ko[0], vo[0]} !== {1'b1, 1'b1, 3'd4, 8'd10, 8'd2}) begin
         n_err++; $display("FAIL ovf_pulse: got ovf=%b/%b cnt=%0d head=%0d/%0d want 1/1 4 10/2", ov[0], ov[1], cnt[0], ko[0], vo[0]);
      end
      cycle(1, 1, 15, 9);
      n_vec++;
      if ({ov[0], cnt[0], ko[0], vo[0]} !== {1'b0, 3'd4, 8'd10, 8'd4}) begin
         n_err++; $display("FAIL replace: got ovf=%b cnt=%0d head=%0d/%0d want 0 4 10/4", ov[0], cnt[0], ko[0], vo[0]);
      end
   endtask

   task automatic test_drain();
      logic [7:0] ek [4];
      logic [7:0] ev [4];
      ek = '{8'd10, 8'd15, 8'd20, 8'd30};
      ev = '{8'd4, 8'd9, 8'd3, 8'd1};
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({ko[0], vo[0]} !== {ek[i], ev[i]}) begin
            n_err++; $display("FAIL drain_%0d: got %0d/%0d want %0d/%0d", i, ko[0], vo[0], ek[i], ev[i]);
         end
         cycle(0, 1, 0, 0);
      end
      n_vec++;
      if ({emp[0], ko[0], vo[0], cnt[0]} !== {1'b1, 8'd0, 8'd0, 3'd0}) begin
         n_err++; $display("FAIL drain_empty: got emp=%b head=%0d/%0d cnt=%0d want 1 0/0 0", emp[0], ko[0], vo[0], cnt[0]);
      end
      cycle(0, 1, 0, 0);
      n_vec++;
      if ({ud[0], ud[1], cnt[0]} !== {1'b1, 1'b1, 3'd0}) begin
         n_err++; $display("FAIL udf_pulse: got udf=%b/%b cnt=%0d want 1/1 0", ud[0], ud[1], cnt[0]);
      end
      cycle(0, 0, 0, 0);
      n_vec++;
      if (ud[0] !== 1'b0) begin
         n_err++; $display("FAIL udf_clear: got %b want 0", ud[0]);
      end
   endtask

   task automatic test_enq_deq_empty();
      cycle(1, 1, 7, 7);
      n_vec++;
      if ({cnt[0], ko[0], vo[0], ud[0], ov[0]} !== {3'd1, 8'd7, 8'd7, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL enqdeq_empty: got cnt=%0d head=%0d/%0d udf=%b ovf=%b want 1 7/7 0 0", cnt[0], ko[0], vo[0], ud[0], ov[0]);
      end
      cycle(0, 1, 0, 0);
   endtask

   task automatic test_max_mode();
      logic [7:0] ek [4];
      logic [7:0] ev [4];
      logic [7:0] bk [3];
      ek = '{8'd9, 8'd9, 8'd3, 8'd1};
      ev = '{8'd2, 8'd3, 8'd1, 8'd4};
      cycle(1, 0, 3, 1);
      cycle(1, 0, 9, 2);
      cycle(1, 0, 9, 3);
      cycle(1, 0, 1, 4);
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({ko[1], vo[1]} !== {ek[i], ev[i]}) begin
            n_err++; $display("FAIL max_order_%0d: got %0d/%0d want %0d/%0d", i, ko[1], vo[1], ek[i], ev[i]);
         end
         cycle(0, 1, 0, 0);
      end
      cycle(1, 0, 0, 1);
      cycle(1, 0, 255, 2);
      cycle(1, 0, 128, 3);
      bk = '{8'd255, 8'd128, 8'd0};
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if ({ko[1], ko[0]} !== {bk[i], bk[2-i]}) begin
            n_err++; $display("FAIL extremes_%0d: got max=%0d min=%0d want %0d %0d", i, ko[1], ko[0], bk[i], bk[2-i]);
         end
         cycle(0, 1, 0, 0);
      end
   endtask

   task automatic test_async_reset();
      cycle(1, 0, 11, 1);
      cycle(1, 0, 12, 2);
      cycle(1, 0, 13, 3);
      n_vec++;
      if ({cnt[0], cnt[1]} !== {3'd3, 3'd3}) begin
         n_err++; $display("FAIL pre_reset_count: got %0d/%0d want 3/3", cnt[0], cnt[1]);
      end
      #2 rst_n = 1'b0;
      #1;
      q0.delete(); q1.delete(); e_ovf = '0; e_udf = '0;
      for (int m = 0; m < 2; m++) begin
         n_vec++;
         if ({emp[m], cnt[m], ko[m], ful[m]} !== {1'b1, 3'd0, 8'd0, 1'b0}) begin
            n_err++; $display("FAIL async_reset_m%0d: got emp=%b cnt=%0d ko=%0d full=%b want 1 0 0 0", m, emp[m], cnt[m], ko[m], ful[m]);
         end
      end
      @(negedge clk) rst_n = 1'b1;
      cycle(1, 0, 42, 42);
      n_vec++;
      if ({ko[0], ko[1], cnt[0]} !== {8'd42, 8'd42, 3'd1}) begin
         n_err++; $display("FAIL post_reset_enq: got ko=%0d/%0d cnt=%0d want 42/42 1", ko[0], ko[1], cnt[0]);
      end
      cycle(0, 1, 0, 0);
   endtask

   task automatic test_random();
      bit e, d;
      int r, pe, pd;
      logic [7:0] k;
      for (int c = 0; c < 600; c++) begin
         // Alternate fill-heavy and drain-heavy phases to reach full and empty.
         pe = ((c / 40) % 2 == 0) ? 75 : 30;
         pd = ((c / 40) % 2 == 0) ? 30 : 75;
         e = ($urandom_range(0, 99) < pe);
         d = ($urandom_range(0, 99) < pd);
         r = $urandom_range(0, 9);
         k = (r == 0) ? 8'd0 : (r == 9) ? 8'd255 : 8'($urandom_range(1, 5));
         cycle(e, d, k, 8'($urandom));
         for (int m = 0; m < 2; m++) begin
            logic [15:0] hd;
            int sz;
            logic [22:0] got, want;
            sz = (m == 0) ? q0.size() : q1.size();
            hd = (sz == 0) ? 16'h0 : ((m == 0) ? q0[0] : q1[0]);
            want = {hd, 3'(sz), (sz == 0), (sz == CAP), e_ovf[m], e_udf[m]};
            got  = {ko[m], vo[m], cnt[m], emp[m], ful[m], ov[m], ud[m]};
            n_vec++;
            if (got !== want) begin
               n_err++;
               $display("FAIL random_m%0d cyc %0d: got {ko,vo,cnt,emp,full,ovf,udf}=%h want %h", m, c, got, want);
            end
         end
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      e_ovf = '0; e_udf = '0;
      rst_n = 1'b0; enq = 1'b0; deq = 1'b0; ki = '0; vi = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk) rst_n = 1'b1;
      test_enq_order();
      test_overflow_replace();
      test_drain();
      test_enq_deq_empty();
      test_max_mode();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sr_pq_r.md
Name: sr_pq_r

Overview:
- Parametrised shift-register priority queue: one-cycle enqueue, dequeue and replace (simultaneous enqueue + dequeue).
- Per-stage valid bits replace the KEYINF sentinel, so the full key range is storable.
- Selectable min/max ordering; stable FIFO order among equal keys.
- Drop-in PQ device for the HWPQ study, with plain ports so width and depth can be parametrised per instance.

Parameters:
- CAPACITY, 16, number of storage stages (>=2).
- KEY_W, 16, key width in bits.
- VAL_W, 16, value width in bits.
- MAX_MODE, 0, 0 = smallest key at head; 1 = largest key at head.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- enq  in  1  enqueue request, sampled every cycle.
- deq  in  1  dequeue request, sampled every cycle.
- ki  in  KEY_W  key to enqueue.
- vi  in  VAL_W  value to enqueue.
- ko  out  KEY_W  head key (stage 1).
- vo  out  VAL_W  head value (stage 1).
- empty  out  1  no valid entries.
- full  out  1  CAPACITY valid entries.
- count  out  $clog2(CAPACITY+1)  number of valid entries.
- ovf  out  1  one-cycle pulse: enqueue dropped because full.
- udf  out  1  one-cycle pulse: dequeue requested while empty.
- busy  out  1  tied 0; every operation completes in one cycle.

Behaviour:
- Storage: stages 1..CAPACITY, each holding valid, key, value.
- Invariants after every clock:
  - Valid stages are contiguous from stage 1.
  - Keys are non-decreasing (MAX_MODE=0) or non-increasing (MAX_MODE=1) toward CAPACITY.
  - Equal keys sit in arrival order.
- Reset (rst=0, asynchronous):
  - All valid=0, key/value=0, count=0.
  - empty=1, full=0, ovf=0, udf=0, ko=0, vo=0.
  - Reset asserted mid-operation discards all contents; the first edge after release behaves as from empty.
- Comparator, per stage j: pass[j] = valid[j] && (MAX_MODE ? key[j] >= ki : key[j] <= ki). Stage j sorts ahead of the new entry when pass[j]=1, which gives FIFO order among equal keys.
- Effective operation, decoded from enq, deq, empty, full:
  - IDLE: no enq, no deq. State holds.
  - ENQ: enq && !deq && !full.
    - Stages with pass=1 hold.
    - The first stage with pass=0 loads {1,ki,vi}.
    - Later stages load from their predecessor; stage CAPACITY's old content is invalid by precondition.
    - count+1.
  - DEQ: deq && !empty (enq=0).
    - Stage i loads stage i+1; stage CAPACITY loads invalid.
    - count-1.
  - REPLACE: enq && deq && !empty. Head is removed and the new entry inserted in one cycle.
    - p = 1 + number of stages j in 2..CAPACITY with pass[j]=1.
    - Stage i<p loads stage i+1; stage p loads {1,ki,vi}; stage i>p holds.
    - count unchanged.
    - Legal when full; ovf=0.
  - enq && deq && empty: treated as ENQ. udf=0.
  - enq && !deq && full: state holds; ovf=1 for the next cycle.
  - deq && empty && !enq: state holds; udf=1 for the next cycle.
- Outputs:
  - ovf and udf are registered; they are 0 in any cycle whose preceding edge had no error.
  - ko/vo come directly from stage-1 registers: a new head is visible the cycle after the operating edge.
  - When empty=1, ko/vo are 0: invalidated stages clear key/value to 0.
  - empty = !valid[1]; full = valid[CAPACITY]. count always equals the number of valid stages.
- ki/vi are ignored when the effective operation is not ENQ/REPLACE. No other state.

Test Plan (CAPACITY=4, KEY_W=8, VAL_W=8, MAX_MODE=0 unless stated):
- Reset, then ENQ keys 30,10,20,10 (values 1,2,3,4) on consecutive cycles -> order 10/2,10/4,20/3,30/1; ko=10, vo=2; count=4; full=1.
- From full, ENQ key 5 -> contents unchanged, ovf=1 for exactly one cycle; then REPLACE key 15/9 -> head 10/4, order 10/4,15/9,20/3,30/1; count=4; ovf=0.
- Four DEQs -> ko sequence 10,15,20,30, then empty=1, ko=0; a fifth DEQ -> udf=1 for one cycle, count=0.
- Empty queue with enq=deq=1, key 7/7 -> count=1, ko=7, udf=0.
- MAX_MODE=1: ENQ 3,9,9,1 -> DEQ order 9(first),9(second),3,1; key 255 and key 0 both storable and ordered correctly.
- Assert rst mid-sequence with count=3, asynchronously between edges -> empty=1 and count=0 immediately; ENQ 42 after release -> ko=42, count=1.
